// File: rtl/sram_march_tester.sv
// March-style write/read-back test engine for a bank of chip-selected SRAM devices.
// Runs W0/R0/W1/R1 passes over every linear address and records pass/fail results.
`timescale 1ns/1ps
module sram_march_tester #(
    parameter int AW   = 20,
    parameter int DW   = 8,
    parameter int NCS  = 4,
    parameter int WAIT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        continuous,
    input  logic [1:0]                  mode,
    input  logic [15:0]                 seed,
    output logic [AW-1:0]               sram_addr,
    output logic [NCS-1:0]              sram_cs_n,
    output logic                        sram_we_n,
    output logic                        sram_oe_n,
    output logic [DW-1:0]               d_out,
    output logic                        d_oe,
    input  logic [DW-1:0]               d_in,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  pass_cnt,
    output logic [15:0]                 err_cnt,
    output logic [AW+$clog2(NCS)-1:0]   fail_addr,
    output logic [DW-1:0]               fail_exp,
    output logic [DW-1:0]               fail_got,
    output logic                        led
);
    localparam int LAW = AW + $clog2(NCS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_W_SETUP = 3'd1,
        S_W_PULSE = 3'd2,
        S_W_HOLD  = 3'd3,
        S_R_SETUP = 3'd4,
        S_R_WAIT  = 3'd5,
        S_R_CMP   = 3'd6,
        S_NEXT    = 3'd7
    } state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    // pass_r[1] selects the inverted phase
    function automatic logic [DW-1:0] pattern(input logic [1:0] m, input logic [LAW-1:0] a,
                                              input logic [15:0] lf, input logic inv);
        logic [DW-1:0] alt;
        logic [DW-1:0] p;
        for (int i = 0; i < DW; i++) alt[i] = (i % 2 == 0);
        case (m)
            2'd0:    p = DW'(lf);
            2'd1:    p = DW'(a);
            2'd2:    p = a[0] ? ~alt : alt;
            2'd3:    p = '0;
            default: p = '0;
        endcase
        return inv ? ~p : p;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [LAW-1:0]  la_r, la_nxt_s, fail_addr_r, fail_addr_nxt_s;
    logic [1:0]      pass_r, pass_nxt_s, mode_r, mode_nxt_s;
    logic [3:0]      wcnt_r, wcnt_nxt_s;
    logic [15:0]     lfsr_r, lfsr_nxt_s, seed_r, seed_nxt_s, err_r, err_nxt_s;
    logic [DW-1:0]   rd_r, rd_nxt_s, fail_exp_r, fail_exp_nxt_s, fail_got_r, fail_got_nxt_s;
    logic [DW-1:0]   exp_s, dout_r;
    logic [7:0]      pass_cnt_r, pass_cnt_nxt_s;
    logic            first_r, first_nxt_s, tog_r, tog_nxt_s, done_nxt_s;
    logic            wr_s, rd_s;
    logic [NCS-1:0]  sel_s, cs_n_r;
    logic [AW-1:0]   addr_r;
    logic            we_n_r, oe_n_r, d_oe_r, busy_r, done_r, led_r;

    assign exp_s = pattern(mode_r, la_r, lfsr_r, pass_r[1]);

    // Next-state and datapath update logic
    always_comb begin
        state_nxt_s     = state_r;
        la_nxt_s        = la_r;
        pass_nxt_s      = pass_r;
        mode_nxt_s      = mode_r;
        wcnt_nxt_s      = wcnt_r;
        lfsr_nxt_s      = lfsr_r;
        seed_nxt_s      = seed_r;
        err_nxt_s       = err_r;
        rd_nxt_s        = rd_r;
        first_nxt_s     = first_r;
        fail_addr_nxt_s = fail_addr_r;
        fail_exp_nxt_s  = fail_exp_r;
        fail_got_nxt_s  = fail_got_r;
        pass_cnt_nxt_s  = pass_cnt_r;
        tog_nxt_s       = tog_r;
        done_nxt_s      = 1'b0;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_nxt_s     = S_W_SETUP;
                        la_nxt_s        = '0;
                        pass_nxt_s      = 2'd0;
                        mode_nxt_s      = mode;
                        seed_nxt_s      = (seed == 16'h0000) ? 16'h0001 : seed;
                        lfsr_nxt_s      = seed_nxt_s;
                        err_nxt_s       = 16'h0000;
                        first_nxt_s     = 1'b0;
                        fail_addr_nxt_s = '0;
                        fail_exp_nxt_s  = '0;
                        fail_got_nxt_s  = '0;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_W_SETUP: begin
                    state_nxt_s = S_W_PULSE;
                    wcnt_nxt_s  = 4'(WAIT);
                end
                S_W_PULSE: begin
                    if (wcnt_r == 4'd0) begin
                        state_nxt_s = S_W_HOLD;
                    end else begin
                        wcnt_nxt_s = wcnt_r - 4'd1;
                    end
                end
                S_W_HOLD:  state_nxt_s = S_NEXT;
                S_R_SETUP: begin
                    state_nxt_s = S_R_WAIT;
                    wcnt_nxt_s  = 4'(WAIT);
                end
                S_R_WAIT: begin
                    if (wcnt_r == 4'd0) begin
                        rd_nxt_s    = d_in;
                        state_nxt_s = S_R_CMP;
                    end else begin
                        wcnt_nxt_s = wcnt_r - 4'd1;
                    end
                end
                S_R_CMP: begin
                    state_nxt_s = S_NEXT;
                    if (rd_r != exp_s) begin
                        err_nxt_s   = (err_r == 16'hFFFF) ? err_r : err_r + 16'd1;
                        first_nxt_s = 1'b1;
                        if (!first_r) begin
                            fail_addr_nxt_s = la_r;
                            fail_exp_nxt_s  = exp_s;
                            fail_got_nxt_s  = rd_r;
                        end else begin
                            fail_addr_nxt_s = fail_addr_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                end
                S_NEXT: begin
                    la_nxt_s   = la_r + LAW'(1);
                    lfsr_nxt_s = lfsr_step(lfsr_r);
                    if (la_r == '1) begin
                        lfsr_nxt_s = seed_r;
                        if (pass_r == 2'd3) begin
                            done_nxt_s     = 1'b1;
                            tog_nxt_s      = ~tog_r;
                            pass_cnt_nxt_s = (err_r == 16'h0000) ? pass_cnt_r + 8'd1 : pass_cnt_r;
                            pass_nxt_s     = 2'd0;
                            state_nxt_s    = continuous ? S_W_SETUP : S_IDLE;
                        end else begin
                            pass_nxt_s  = pass_r + 2'd1;
                            state_nxt_s = pass_r[0] ? S_W_SETUP : S_R_SETUP;
                        end
                    end else begin
                        state_nxt_s = pass_r[0] ? S_R_SETUP : S_W_SETUP;
                    end
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Pin decode for the upcoming state, so the pins line up with the state register
    always_comb begin
        wr_s  = (state_nxt_s == S_W_SETUP) || (state_nxt_s == S_W_PULSE) || (state_nxt_s == S_W_HOLD);
        rd_s  = (state_nxt_s == S_R_SETUP) || (state_nxt_s == S_R_WAIT);
        sel_s = NCS'(1'b1) << (la_nxt_s >> AW);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            la_r        <= '0;
            pass_r      <= 2'd0;
            mode_r      <= 2'd0;
            wcnt_r      <= 4'd0;
            lfsr_r      <= 16'h0000;
            seed_r      <= 16'h0000;
            err_r       <= 16'h0000;
            rd_r        <= '0;
            first_r     <= 1'b0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_got_r  <= '0;
            pass_cnt_r  <= 8'd0;
            tog_r       <= 1'b0;
            addr_r      <= '0;
            cs_n_r      <= {NCS{1'b1}};
            we_n_r      <= 1'b1;
            oe_n_r      <= 1'b1;
            d_oe_r      <= 1'b0;
            dout_r      <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            led_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            la_r        <= la_nxt_s;
            pass_r      <= pass_nxt_s;
            mode_r      <= mode_nxt_s;
            wcnt_r      <= wcnt_nxt_s;
            lfsr_r      <= lfsr_nxt_s;
            seed_r      <= seed_nxt_s;
            err_r       <= err_nxt_s;
            rd_r        <= rd_nxt_s;
            first_r     <= first_nxt_s;
            fail_addr_r <= fail_addr_nxt_s;
            fail_exp_r  <= fail_exp_nxt_s;
            fail_got_r  <= fail_got_nxt_s;
            pass_cnt_r  <= pass_cnt_nxt_s;
            tog_r       <= tog_nxt_s;
            addr_r      <= la_nxt_s[AW-1:0];
            cs_n_r      <= (wr_s || rd_s) ? ~sel_s : {NCS{1'b1}};
            we_n_r      <= ~(state_nxt_s == S_W_PULSE);
            oe_n_r      <= ~rd_s;
            d_oe_r      <= wr_s;
            dout_r      <= pattern(mode_nxt_s, la_nxt_s, lfsr_nxt_s, pass_nxt_s[1]);
            busy_r      <= (state_nxt_s != S_IDLE);
            done_r      <= done_nxt_s;
            led_r       <= (err_nxt_s != 16'h0000) || tog_nxt_s;
        end
    end

    assign sram_addr = addr_r;
    assign sram_cs_n = cs_n_r;
    assign sram_we_n = we_n_r;
    assign sram_oe_n = oe_n_r;
    assign d_out     = dout_r;
    assign d_oe      = d_oe_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass_cnt  = pass_cnt_r;
    assign err_cnt   = err_r;
    assign fail_addr = fail_addr_r;
    assign fail_exp  = fail_exp_r;
    assign fail_got  = fail_got_r;
    assign led       = led_r;
endmodule

// File: tb/tb_sram_march_tester.sv
// Directed bench for sram_march_tester: 2 chips x 16 words x 8 bits, WAIT=1,
// with a behavioural SRAM model that can force chip 1 data bit 3 to read as 0.
`timescale 1ns/1ps
module tb_sram_march_tester;
    localparam int AW = 4, DW = 8, NCS = 2, WAIT = 1, LAW = 5;

    logic            clk = 1'b0;
    logic            rst_n, start, abort, continuous;
    logic [1:0]      mode;
    logic [15:0]     seed;
    logic [AW-1:0]   sram_addr;
    logic [NCS-1:0]  sram_cs_n;
    logic            sram_we_n, sram_oe_n, d_oe, busy, done, led;
    logic [DW-1:0]   d_out, d_in, fail_exp, fail_got;
    logic [7:0]      pass_cnt;
    logic [15:0]     err_cnt;
    logic [LAW-1:0]  fail_addr, m_la;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem [0:31];
    logic        stuck = 1'b0, rec = 1'b0, we_q = 1'b1, strobe_bad = 1'b0;
    logic [7:0]  wr_q[$];
    logic [7:0]  q0[$];

    always #5 clk = ~clk;

    sram_march_tester #(.AW(AW), .DW(DW), .NCS(NCS), .WAIT(WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .continuous(continuous),
        .mode(mode), .seed(seed), .sram_addr(sram_addr), .sram_cs_n(sram_cs_n),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .d_out(d_out), .d_oe(d_oe),
        .d_in(d_in), .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got), .led(led));

    // chip 1 is selected when cs_n == 2'b01, so cs_n[0] is the chip index bit
    assign m_la = {sram_cs_n[0], sram_addr};
    assign d_in = (!sram_oe_n && sram_cs_n != 2'b11) ?
                  (mem[m_la] & ((stuck && sram_cs_n[0]) ? 8'hF7 : 8'hFF)) : 8'h00;

    always @(posedge clk) begin
        if (!sram_we_n && sram_cs_n != 2'b11 && d_oe) mem[m_la] <= d_out;
        if (rec && !sram_we_n && we_q) wr_q.push_back(d_out);
        if ((!sram_we_n || !sram_oe_n) && sram_cs_n == 2'b11) strobe_bad <= 1'b1;
        we_q <= sram_we_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cs_n"}, 32'(sram_cs_n), 32'h3);
        chk({tag, "_we_n"}, 32'(sram_we_n), 32'h1);
        chk({tag, "_oe_n"}, 32'(sram_oe_n), 32'h1);
        chk({tag, "_d_oe"}, 32'(d_oe), 32'h0);
        chk({tag, "_addr"}, 32'(sram_addr), 32'h0);
        chk({tag, "_d_out"}, 32'(d_out), 32'h0);
        chk({tag, "_busy_done_led"}, 32'({busy, done, led}), 32'h0);
        chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'h0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
        chk({tag, "_fail_addr"}, 32'(fail_addr), 32'h0);
        chk({tag, "_fail_exp_got"}, 32'({fail_exp, fail_got}), 32'h0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        while (n < max && !ok) begin
            @(negedge clk);
            n++;
            if (done) ok = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit ok;
        bit found;
        int ndiff;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        mode = 2'd0; seed = 16'h0000;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        // mode 1, clean SRAM: 4 passes x 32 addresses x 5 cycles
        mode = 2'd1;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'h1);
        wait_done(2000, n, ok);
        chk("t1_done_seen", 32'(ok), 32'h1);
        chk("t1_cycles", 32'(n), 32'd640);
        chk("t1_pass_cnt", 32'(pass_cnt), 32'd1);
        chk("t1_err_cnt", 32'(err_cnt), 32'd0);
        chk("t1_led", 32'(led), 32'h1);

        // chip 1 bit 3 stuck at 0, solid pattern: only R1 on chip 1 fails
        stuck = 1'b1; mode = 2'd3;
        pulse_start();
        wait_done(2000, n, ok);
        chk("t2_done_seen", 32'(ok), 32'h1);
        chk("t2_err_cnt", 32'(err_cnt), 32'd16);
        chk("t2_fail_addr", 32'(fail_addr), 32'd16);
        chk("t2_fail_exp", 32'(fail_exp), 32'hFF);
        chk("t2_fail_got", 32'(fail_got), 32'hF7);
        chk("t2_led", 32'(led), 32'h1);
        chk("t2_pass_cnt", 32'(pass_cnt), 32'd1);
        stuck = 1'b0;

        // LFSR, seed 0 (replaced by 1): 0001,B400,5A00,2D00,1680,0B40,05A0,02D0,0168,00B4,005A,002D,B416
        mode = 2'd0; seed = 16'h0000;
        wr_q.delete(); rec = 1'b1;
        pulse_start();
        wait_done(2000, n, ok);
        rec = 1'b0;
        chk("t3_seed0_done", 32'(ok), 32'h1);
        chk("t3_seed0_writes", 32'(wr_q.size()), 32'd64);
        q0 = wr_q;
        chk("t3_w0_first", 32'(q0[0]), 32'h01);
        chk("t3_w0_la9", 32'(q0[9]), 32'hB4);
        chk("t3_w0_la12", 32'(q0[12]), 32'h16);
        chk("t3_w1_first", 32'(q0[32]), 32'hFE);
        chk("t3_w1_la9", 32'(q0[41]), 32'h4B);
        chk("t3_seed0_pass_cnt", 32'(pass_cnt), 32'd2);
        seed = 16'h0001;
        wr_q.delete(); rec = 1'b1;
        pulse_start();
        wait_done(2000, n, ok);
        rec = 1'b0;
        chk("t3_seed1_writes", 32'(wr_q.size()), 32'd64);
        ndiff = 0;
        for (int i = 0; i < 64; i++) if (wr_q[i] !== q0[i]) ndiff++;
        chk("t3_seed0_vs_seed1", 32'(ndiff), 32'd0);
        chk("t3_seed1_err_cnt", 32'(err_cnt), 32'd0);
        chk("t3_seed1_pass_cnt", 32'(pass_cnt), 32'd3);
        chk("t3_led_toggled_off", 32'(led), 32'h0);

        // abort in W_PULSE
        mode = 2'd1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (!sram_we_n) found = 1'b1;
            else @(negedge clk);
        end
        chk("abort_reach_wpulse", 32'(found), 32'h1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_we_n", 32'(sram_we_n), 32'h1);
        chk("abort_cs_n", 32'(sram_cs_n), 32'h3);
        chk("abort_d_oe", 32'(d_oe), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        wait_done(700, n, ok);
        chk("abort_no_done", 32'(ok), 32'h0);
        chk("abort_pass_cnt_kept", 32'(pass_cnt), 32'd3);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'h0);

        // continuous runs from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        continuous = 1'b1; mode = 2'd1;
        pulse_start();
        wait_done(2000, n, ok);
        chk("cont_run1_cycles", 32'(n), 32'd640);
        wait_done(2000, n, ok);
        chk("cont_run2_spacing", 32'(n), 32'd640);
        wait_done(2000, n, ok);
        chk("cont_run3_spacing", 32'(n), 32'd640);
        chk("cont_pass_cnt", 32'(pass_cnt), 32'd3);
        continuous = 1'b0;
        wait_done(2000, n, ok);
        chk("cont_final_done", 32'(ok), 32'h1);
        chk("cont_idle_after", 32'(busy), 32'h0);
        chk("cont_pass_cnt4", 32'(pass_cnt), 32'd4);
        chk("strobe_only_with_cs", 32'(strobe_bad), 32'h0);

        // asynchronous reset in the middle of a failing run
        stuck = 1'b1; mode = 2'd3;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            if (err_cnt == 16'd5) found = 1'b1;
            else @(negedge clk);
        end
        chk("async_reach_err5", 32'(found), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
